// File: rtl/button_debounce_bank.sv
// N_BTN-channel pushbutton front end: 2-FF synchroniser, counter debouncer and one-cycle press/release pulses.
// Define BTN_REPEAT_EN to build per-channel auto-repeat; otherwise btn_repeat is tied to 0.
module button_debounce_bank #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] press_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          accept;

    // A new level is accepted on the edge where the counter has already seen it DEBOUNCE_CYCLES-1 times.
    assign accept     = (sync2 != level_q) && (cnt == CNT_LAST);
    assign press_d[i] = accept && sync2;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1     <= 1'b0;
        sync2     <= 1'b0;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync1     <= btn_in[i];
        sync2     <= sync1;
        press_q   <= accept && sync2;
        release_q <= accept && !sync2;
        if (sync2 == level_q) begin
          cnt <= '0;
        end else if (accept) begin
          cnt     <= '0;
          level_q <= sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

`ifdef BTN_REPEAT_EN
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    logic [HW-1:0] hold;
    logic          rep_phase;
    logic          rep_q;
    logic          fire;

    // hold counts cycles since the press pulse (first period) or since the last repeat pulse.
    // A release being accepted this edge suppresses the pulse so repeat never overlaps release.
    assign fire = level_q && !accept && (rep_phase ? (hold == REP_LAST) : (hold == HOLD_LAST));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold      <= '0;
        rep_phase <= 1'b0;
        rep_q     <= 1'b0;
      end else if (!level_q) begin
        hold      <= '0;
        rep_phase <= 1'b0;
        rep_q     <= 1'b0;
      end else if (fire) begin
        hold      <= '0;
        rep_phase <= 1'b1;
        rep_q     <= 1'b1;
      end else begin
        hold  <= hold + HW'(1);
        rep_q <= 1'b0;
      end
    end

    assign btn_repeat[i] = rep_q;
`else
    assign btn_repeat[i] = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_d;
    end
  end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3, N_BTN=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_button_debounce_bank;

  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int REP  = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;
  logic         any_press;

  int   vectors     = 0;
  int   miscompares = 0;
  logic rep_seen    = 1'b0;
  logic overlap     = 1'b0;
  bit   rep_en;

  always #5 clk = ~clk;

  button_debounce_bank #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat), .any_press(any_press)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rep_seen = rep_seen | (|btn_repeat);
    overlap  = overlap | (|(btn_press & btn_release));
  endtask

  initial begin
`ifdef BTN_REPEAT_EN
    rep_en = 1'b1;
`else
    rep_en = 1'b0;
`endif
    // Reset held with all buttons pressed: everything stays low.
    reset  = 1'b1;
    btn_in = 4'hF;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("rst_level", btn_level, 4'h0);
      chk("rst_press", btn_press, 4'h0);
      chk("rst_release", btn_release, 4'h0);
      chk("rst_repeat", btn_repeat, 4'h0);
      chk("rst_any", {3'b0, any_press}, 4'h0);
    end
    reset = 1'b0;
    for (int t = 0; t <= 6; t++) begin
      tick();
      chk("post_rst_press", btn_press, (t == 5) ? 4'hF : 4'h0);
      chk("post_rst_any", {3'b0, any_press}, (t == 5) ? 4'h1 : 4'h0);
      chk("post_rst_level", btn_level, (t >= 5) ? 4'hF : 4'h0);
    end

    // All released together.
    btn_in = 4'h0;
    for (int t = 0; t <= 6; t++) begin
      tick();
      chk("rel_all", btn_release, (t == 5) ? 4'hF : 4'h0);
      chk("rel_all_level", btn_level, (t >= 5) ? 4'h0 : 4'hF);
      chk("rel_all_press", btn_press, 4'h0);
    end

    // Channel 0 press, long hold (repeat window), then release.
    btn_in = 4'b0001;
    for (int t = 0; t <= 5; t++) begin
      tick();
      chk("b0_press", btn_press, (t == 5) ? 4'b0001 : 4'b0000);
      chk("b0_any", {3'b0, any_press}, (t == 5) ? 4'h1 : 4'h0);
    end
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk("b0_hold_press", btn_press, 4'b0000);
      chk("b0_repeat", btn_repeat,
          (rep_en && k >= HOLD && ((k - HOLD) % REP) == 0 && k < 26) ? 4'b0001 : 4'b0000);
      chk("b0_release", btn_release, (k == 26) ? 4'b0001 : 4'b0000);
      chk("b0_level", btn_level, (k < 26) ? 4'b0001 : 4'b0000);
      if (k == 20) btn_in = 4'b0000;
    end

    // Channel 1 bounces with 2-cycle highs: never accepted.
    for (int r = 0; r < 2; r++) begin
      btn_in = 4'b0010;
      tick(); chk("b1_glitch_press", btn_press, 4'h0);
      tick(); chk("b1_glitch_level", btn_level, 4'h0);
      btn_in = 4'b0000;
      tick(); chk("b1_glitch_press", btn_press, 4'h0);
      tick(); chk("b1_glitch_level", btn_level, 4'h0);
    end
    for (int t = 0; t < 8; t++) begin
      tick();
      chk("b1_settle_press", btn_press, 4'h0);
      chk("b1_settle_level", btn_level, 4'h0);
    end

    // Channel 2: high 3, low 1, then held high; one press counted from the last rise.
    btn_in = 4'b0100;
    for (int t = 0; t < 3; t++) begin
      tick(); chk("b2_first_press", btn_press, 4'h0);
    end
    btn_in = 4'b0000;
    tick(); chk("b2_dip_press", btn_press, 4'h0);
    btn_in = 4'b0100;
    for (int t = 0; t <= 7; t++) begin
      tick();
      chk("b2_press", btn_press, (t == 5) ? 4'b0100 : 4'b0000);
      chk("b2_level", btn_level, (t >= 5) ? 4'b0100 : 4'b0000);
    end

    // Channels 0 and 3 rise together while 2 stays held.
    btn_in = 4'b1101;
    for (int t = 0; t <= 6; t++) begin
      tick();
      chk("b03_press", btn_press, (t == 5) ? 4'b1001 : 4'b0000);
      chk("b03_any", {3'b0, any_press}, (t == 5) ? 4'h1 : 4'h0);
      chk("b03_level", btn_level, (t >= 5) ? 4'b1101 : 4'b0100);
    end

    chk("press_release_overlap", {3'b0, overlap}, 4'h0);
    if (!rep_en) chk("repeat_never", {3'b0, rep_seen}, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
